// File: rtl/pmem_responder_pkg.sv
// Shared types for the physical-memory responder.
// Provides the LC-3b word/line types, the responder FSM state encoding,
// the line offset width and a saturating counter helper.
package pmem_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  localparam int unsigned LINE_OFFSET_BITS = 4;
  localparam int unsigned STAT_W           = 16;
  localparam int unsigned CNT_W            = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } pmem_state_t;

  // Increment that sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the responder: LINES x 128-bit, synchronous write,
// combinational read, no reset (contents survive reset).
// Ports:
//   clk      rising-edge clock
//   write    write enable, commits datain to line[index] at the edge
//   index    line index
//   datain   line to write
//   dataout  line[index], combinational
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LINES = 256,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             write,
  input  logic [IDX_W-1:0] index,
  input  lc3b_data         datain,
  output lc3b_data         dataout
);

  lc3b_data mem_q [LINES];

  always_ff @(posedge clk) begin
    if (write) begin
      mem_q[index] <= datain;
    end
  end

  assign dataout = mem_q[index];

endmodule

// File: rtl/pmem_responder.sv
// Main-memory responder for the physical side of the LC-3b cache.
// Accepts whole-line reads and writebacks, answers with a one-cycle
// pmem_resp LATENCY cycles after acceptance, then spends one turnaround
// cycle so the cache can drop its request before a new one is taken.
// Optional build macro PMEM_STATS_EN adds saturating read/write counters.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pmem_read/write   line request, held by the cache until pmem_resp
//   pmem_address      byte address, bits [3:0] ignored, upper bits alias
//   pmem_wdata        writeback line
//   pmem_rdata        read line, updated only when a read completes
//   pmem_resp         single-cycle completion pulse
//   pmem_error        sticky; read and write seen together
//   read_count/write_count  (PMEM_STATS_EN) completed ops, saturating
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned LINES   = 256
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_data pmem_wdata,
  output lc3b_data pmem_rdata,
  output logic     pmem_resp,
  output logic     pmem_error
`ifdef PMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] read_count,
  output logic [STAT_W-1:0] write_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);

  pmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  lc3b_data         wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic             resp_q, resp_d;
  lc3b_data         rdata_q, rdata_d;

  lc3b_data         line_rdata;
  logic             line_we;

  // Only the index field of the address is decoded.
  logic unused_addr;
  assign unused_addr = ^pmem_address;

  // Writes commit at the end of the RESP cycle, even if reset is high then.
  assign line_we = (state_q == RESP) && wr_q;

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_lines (
    .clk     (clk),
    .write   (line_we),
    .index   (idx_q),
    .datain  (wdata_q),
    .dataout (line_rdata)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d   = pmem_address[LINE_OFFSET_BITS +: IDX_W];
          wdata_d = pmem_wdata;
          wr_d    = pmem_write;  // read+write together resolves to a write
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
          if (pmem_read && pmem_write) begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          resp_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = line_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request payload; meaningful only while a transaction is open.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign pmem_error = err_q;

`ifdef PMEM_STATS_EN
  logic [STAT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Count completions in their RESP cycle.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == RESP) begin
      if (wr_q) begin
        wr_cnt_d = sat_inc(wr_cnt_q);
      end else begin
        rd_cnt_d = sat_inc(rd_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder (LATENCY=4, LINES=256).
module tb_pmem_responder;
  import pmem_responder_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     pmem_read;
  logic     pmem_write;
  lc3b_word pmem_address;
  lc3b_data pmem_wdata;
  lc3b_data pmem_rdata;
  logic     pmem_resp;
  logic     pmem_error;
`ifdef PMEM_STATS_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  int pass_count  = 0;
  int total_count = 0;
  int cyc         = 0;

  pmem_responder #(
    .LATENCY (4),
    .LINES   (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_error   (pmem_error)
`ifdef PMEM_STATS_EN
    ,
    .read_count   (read_count),
    .write_count  (write_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Wait (bounded) for a resp pulse, sampling on falling edges.
  task automatic wait_resp(output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  // Issue one request, hold it until resp, drop it in the resp cycle.
  task automatic req(input logic rd, input logic wr, input lc3b_word addr,
                     input lc3b_data wd, output int lat, output lc3b_data rdat);
    int start;
    int at;
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    start        = cyc;
    wait_resp(at);
    lat  = (at < 0) ? -1 : at - start - 1;
    rdat = pmem_rdata;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  localparam lc3b_data V1  = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam lc3b_data V3  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam lc3b_data V5  = 128'hCAFEF00D_13579BDF_2468ACE0_0F1E2D3C;
  localparam lc3b_data VAA = {16{8'hAA}};
  localparam lc3b_data V55 = {16{8'h55}};

  initial begin
    int       lat;
    int       c1;
    int       c2;
    int       pulses;
    lc3b_data rd;

    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    repeat (2) @(negedge clk);
    check("rst_resp",  128'(pmem_resp),  128'(0));
    check("rst_error", 128'(pmem_error), 128'(0));
    check("rst_rdata", pmem_rdata, 128'(0));
    reset = 1'b0;

    // Write then read back with fixed latency.
    req(1'b0, 1'b1, 16'h1234, V1, lat, rd);
    check("t1_wr_lat", 128'(lat), 128'(4));
    check("t1_wr_rdata_hold", rd, 128'(0));
    @(negedge clk);
    check("t1_resp_single", 128'(pmem_resp), 128'(0));
    req(1'b1, 1'b0, 16'h1230, '0, lat, rd);
    check("t1_rd_lat", 128'(lat), 128'(4));
    check("t1_rd_data", rd, V1);

    // Held request: TURN refuses it, IDLE accepts it one cycle later.
    @(negedge clk);
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h1230;
    wait_resp(c1);
    @(negedge clk);
    check("t2_turn_no_resp", 128'(pmem_resp), 128'(0));
    wait_resp(c2);
    pmem_read = 1'b0;
    check("t2_first_seen", 128'(c1 >= 0), 128'(1));
    check("t2_interval", 128'(c2 - c1), 128'(7));
    check("t2_interval_min", 128'((c2 - c1) >= 6), 128'(1));
    check("t2_rdata", pmem_rdata, V1);

    // Read and write together: write wins, error is sticky.
    @(negedge clk);
    req(1'b1, 1'b1, 16'h0040, V3, lat, rd);
    check("t3_lat", 128'(lat), 128'(4));
    check("t3_error_set", 128'(pmem_error), 128'(1));
    check("t3_rdata_hold", rd, V1);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0040, '0, lat, rd);
    check("t3_write_done", rd, V3);
    check("t3_error_sticky", 128'(pmem_error), 128'(1));

    // Reset during BUSY of an overwrite discards it.
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0080, VAA, lat, rd);
    check("t4_pre_lat", 128'(lat), 128'(4));
    @(negedge clk);
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0080;
    pmem_wdata   = V55;
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    pmem_write = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) pulses++;
    end
    check("t4_no_resp", 128'(pulses), 128'(0));
    check("t4_error_cleared", 128'(pmem_error), 128'(0));
    check("t4_rdata_cleared", pmem_rdata, 128'(0));
    req(1'b1, 1'b0, 16'h0080, '0, lat, rd);
    check("t4_lat", 128'(lat), 128'(4));
    check("t4_kept", rd, VAA);

    // Upper address bits alias onto the same line.
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0010, V5, lat, rd);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h1010, '0, lat, rd);
    check("t5_alias", rd, V5);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0040, '0, lat, rd);
    check("t5_other_line", rd, V3);

`ifdef PMEM_STATS_EN
    // Completion counters.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rd_cnt_rst", 128'(read_count),  128'(0));
    check("t6_wr_cnt_rst", 128'(write_count), 128'(0));
    req(1'b1, 1'b0, 16'h0010, '0, lat, rd);
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0020, V1, lat, rd);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0020, '0, lat, rd);
    @(negedge clk);
    req(1'b0, 1'b1, 16'h0030, V3, lat, rd);
    @(negedge clk);
    req(1'b1, 1'b0, 16'h0030, '0, lat, rd);
    @(negedge clk);
    check("t6_rd_cnt", 128'(read_count),  128'(3));
    check("t6_wr_cnt", 128'(write_count), 128'(2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rd_cnt_clr", 128'(read_count),  128'(0));
    check("t6_wr_cnt_clr", 128'(write_count), 128'(0));
`endif

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
